uart_frame_parser: RTL and testbench

- Byte-level command-frame parser directly downstream of the UART RX logic. It consumes the one-cycle byte strobe and data byte that the receiver produces.
- Frame format: HDR0, HDR1, CMD, LEN, LEN payload bytes, CHK. CHK is the 8-bit modulo-256 sum of CMD, LEN and all payload bytes.
- Streams payload bytes to the command/register layer, then reports frame-good or frame-error with a reason code.
- Inter-byte timeout recovers from truncated frames.

---
 rtl/uart_frame_parser_if.sv | 30 +++
 rtl/uart_frame_parser.sv | 145 ++++++++++++++
 tb/tb_uart_frame_parser.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_if.sv
// Byte-stream input and frame/payload output bundle of the UART command-frame parser.
interface uart_frame_parser_if;
  logic       rx_data_flag_i;
  logic [7:0] rx_data_i;
  logic       busy_o;
  logic [7:0] cmd_o;
  logic [7:0] len_o;
  logic       pld_valid_o;
  logic [7:0] pld_data_o;
  logic [7:0] pld_index_o;
  logic       frame_ok_o;
  logic       frame_err_o;
  logic [1:0] err_code_o;
  logic [7:0] err_cnt_o;
  logic [2:0] state_dbg;

  // rx_data_flag_i is a one-cycle strobe qualifying rx_data_i; there is no backpressure,
  // so every strobed byte is consumed in the cycle it is presented.
  modport master (
    output rx_data_flag_i, rx_data_i,
    input  busy_o, cmd_o, len_o, pld_valid_o, pld_data_o, pld_index_o,
           frame_ok_o, frame_err_o, err_code_o, err_cnt_o, state_dbg
  );

  modport slave (
    input  rx_data_flag_i, rx_data_i,
    output busy_o, cmd_o, len_o, pld_valid_o, pld_data_o, pld_index_o,
           frame_ok_o, frame_err_o, err_code_o, err_cnt_o, state_dbg
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Parses HDR0 HDR1 CMD LEN payload CHK frames from a UART byte strobe, streams the
// payload and reports frame-good / frame-error with a held reason code.
module uart_frame_parser #(
  parameter logic [7:0] HDR0           = 8'h55,
  parameter logic [7:0] HDR1           = 8'hAA,
  parameter int         MAX_LEN        = 32,
  parameter int         TIMEOUT_CYCLES = 500000
) (
  input logic               sys_clk_i,
  input logic               rst_n_i,
  uart_frame_parser_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_H1   = 3'd1;
  localparam logic [2:0] S_CMD  = 3'd2;
  localparam logic [2:0] S_LEN  = 3'd3;
  localparam logic [2:0] S_PLD  = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;

  localparam int              TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      LEN_MAX = 8'(MAX_LEN);

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [7:0]    sum;
  logic [7:0]    idx;
  logic [7:0]    cmd_r, len_r, pld_data_r, pld_index_r, err_cnt_r;
  logic          pld_valid_r, ok_r, err_r;
  logic [1:0]    err_code_r;
  logic          strobe;
  logic [7:0]    rx;
  logic          err_fire;
  logic [1:0]    err_reason;

  assign strobe = bus.rx_data_flag_i;
  assign rx     = bus.rx_data_i;

  // A strobe always beats the timeout, so at most one reason can fire per cycle.
  always_comb begin
    err_fire   = 1'b0;
    err_reason = 2'b00;
    if (strobe) begin
      if (state == S_LEN && rx > LEN_MAX) begin
        err_fire   = 1'b1;
        err_reason = 2'b10;
      end else if (state == S_CHK && rx != sum) begin
        err_fire   = 1'b1;
        err_reason = 2'b01;
      end
    end else if (state != S_IDLE && timer == T_LAST) begin
      err_fire   = 1'b1;
      err_reason = 2'b11;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      timer       <= '0;
      sum         <= '0;
      idx         <= '0;
      cmd_r       <= '0;
      len_r       <= '0;
      pld_valid_r <= 1'b0;
      pld_data_r  <= '0;
      pld_index_r <= '0;
      ok_r        <= 1'b0;
    end else begin
      pld_valid_r <= 1'b0;
      ok_r        <= 1'b0;
      if (strobe) begin
        timer <= '0;
        case (state)
          S_IDLE: if (rx == HDR0) state <= S_H1;
          S_H1: begin
            if (rx == HDR1)      state <= S_CMD;
            else if (rx != HDR0) state <= S_IDLE;
          end
          S_CMD: begin
            cmd_r <= rx;
            sum   <= rx;
            state <= S_LEN;
          end
          S_LEN: begin
            len_r <= rx;
            sum   <= sum + rx;
            idx   <= '0;
            if (rx > LEN_MAX)   state <= S_IDLE;
            else if (rx == '0)  state <= S_CHK;
            else                state <= S_PLD;
          end
          S_PLD: begin
            pld_valid_r <= 1'b1;
            pld_data_r  <= rx;
            pld_index_r <= idx;
            sum         <= sum + rx;
            idx         <= idx + 8'd1;
            if (idx == len_r - 8'd1) state <= S_CHK;
          end
          S_CHK: begin
            ok_r  <= (rx == sum);
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (state == S_IDLE) begin
        timer <= '0;
      end else if (timer == T_LAST) begin
        timer <= '0;
        state <= S_IDLE;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_r      <= 1'b0;
      err_code_r <= 2'b00;
      err_cnt_r  <= '0;
    end else begin
      err_r <= err_fire;
      if (err_fire) begin
        err_code_r <= err_reason;
        if (err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  assign bus.busy_o      = (state != S_IDLE);
  assign bus.cmd_o       = cmd_r;
  assign bus.len_o       = len_r;
  assign bus.pld_valid_o = pld_valid_r;
  assign bus.pld_data_o  = pld_data_r;
  assign bus.pld_index_o = pld_index_r;
  assign bus.frame_ok_o  = ok_r;
  assign bus.frame_err_o = err_r;
  assign bus.err_code_o  = err_code_r;
  assign bus.err_cnt_o   = err_cnt_r;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: frame table plus hand-written corner sequences.
module tb_uart_frame_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_frame_parser_if bus();

  uart_frame_parser #(
    .HDR0(8'h55), .HDR1(8'hAA), .MAX_LEN(32), .TIMEOUT_CYCLES(100)
  ) dut (
    .sys_clk_i(clk),
    .rst_n_i  (rst_n),
    .bus      (bus)
  );

  localparam logic [1:0] K_PLD = 2'd1;
  localparam logic [1:0] K_OK  = 2'd2;
  localparam logic [1:0] K_ERR = 2'd3;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] len;
    logic [7:0] p0;
    logic [7:0] step;
    logic [7:0] chk;
    bit         ok;
    bit         dup;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [17:0] exp_q[$];
  logic [7:0] exp_cnt = 8'h00;
  logic [1:0] exp_code = 2'b00;
  vec_t       vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] ev(input logic [1:0] kind, input logic [7:0] data,
                                     input logic [7:0] idx);
    return {kind, data, idx};
  endfunction

  task automatic push_err(input logic [1:0] code);
    exp_q.push_back(ev(K_ERR, {6'b0, code}, 8'h00));
    exp_code = code;
    if (exp_cnt != 8'hFF) exp_cnt++;
  endtask

  // Output monitor: every pulse seen must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    logic [17:0] act;
    logic [17:0] e;
    if (rst_n && (bus.pld_valid_o || bus.frame_ok_o || bus.frame_err_o)) begin
      if ((bus.pld_valid_o && (bus.frame_ok_o || bus.frame_err_o)) ||
          (bus.frame_ok_o && bus.frame_err_o)) begin
        checks++;
        errors++;
        $display("FAIL pulse_excl: pld=%0b ok=%0b err=%0b required one-hot", bus.pld_valid_o,
                 bus.frame_ok_o, bus.frame_err_o);
      end
      if (bus.pld_valid_o)     act = ev(K_PLD, bus.pld_data_o, bus.pld_index_o);
      else if (bus.frame_ok_o) act = ev(K_OK, 8'h00, 8'h00);
      else                     act = ev(K_ERR, {6'b0, bus.err_code_o}, 8'h00);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %0h expected none at %0t", act, $time);
      end else begin
        e = exp_q.pop_front();
        check("event", act, e);
      end
    end
  end

  // Caller sits 1 time unit after a posedge; strobes one cycle, then idles gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data_flag_i = 1'b1;
    bus.rx_data_i      = b;
    @(posedge clk); #1;
    bus.rx_data_flag_i = 1'b0;
    bus.rx_data_i      = 8'h00;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input vec_t v);
    logic [7:0] b;
    if (v.dup) send_byte(8'h55, $urandom_range(0, 3));
    send_byte(8'h55, $urandom_range(0, 3));
    send_byte(8'hAA, $urandom_range(0, 3));
    send_byte(v.cmd, $urandom_range(0, 3));
    send_byte(v.len, $urandom_range(0, 3));
    for (int i = 0; i < int'(v.len); i++) begin
      b = v.p0 + 8'(i) * v.step;
      exp_q.push_back(ev(K_PLD, b, 8'(i)));
      send_byte(b, $urandom_range(0, 3));
    end
    if (v.ok) exp_q.push_back(ev(K_OK, 8'h00, 8'h00));
    else      push_err(2'b01);
    send_byte(v.chk, 0);
  endtask

  // Called in the cycle right after the CHK strobe, where the response must be visible.
  task automatic check_after(input vec_t v);
    check("frame_ok", bus.frame_ok_o, v.ok);
    check("frame_err", bus.frame_err_o, !v.ok);
    check("busy_after", bus.busy_o, 1'b0);
    check("cmd_o", bus.cmd_o, v.cmd);
    check("len_o", bus.len_o, v.len);
    check("err_code", bus.err_code_o, exp_code);
    check("err_cnt", bus.err_cnt_o, exp_cnt);
  endtask

  initial begin
    int   seen;
    vec_t s;

    vecs[0] = '{cmd:8'h10, len:8'd3,  p0:8'h01, step:8'h01, chk:8'h19, ok:1'b1, dup:1'b0};
    vecs[1] = '{cmd:8'h10, len:8'd3,  p0:8'h01, step:8'h01, chk:8'h18, ok:1'b0, dup:1'b0};
    vecs[2] = '{cmd:8'h05, len:8'd0,  p0:8'h00, step:8'h00, chk:8'h05, ok:1'b1, dup:1'b0};
    vecs[3] = '{cmd:8'h20, len:8'd2,  p0:8'h80, step:8'h80, chk:8'hA2, ok:1'b1, dup:1'b0};
    vecs[4] = '{cmd:8'hFF, len:8'd1,  p0:8'h02, step:8'h00, chk:8'h02, ok:1'b1, dup:1'b0};
    vecs[5] = '{cmd:8'h01, len:8'd32, p0:8'h00, step:8'h01, chk:8'h11, ok:1'b1, dup:1'b0};
    vecs[6] = '{cmd:8'h33, len:8'd4,  p0:8'h10, step:8'h10, chk:8'hD8, ok:1'b0, dup:1'b0};
    vecs[7] = '{cmd:8'h01, len:8'd32, p0:8'hFF, step:8'h00, chk:8'h01, ok:1'b1, dup:1'b1};
    vecs[8] = '{cmd:8'h01, len:8'd32, p0:8'hFF, step:8'h00, chk:8'h02, ok:1'b0, dup:1'b1};

    bus.rx_data_flag_i = 1'b0;
    bus.rx_data_i      = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_cmd", bus.cmd_o, 8'h00);
    check("rst_len", bus.len_o, 8'h00);
    check("rst_pld_valid", bus.pld_valid_o, 1'b0);
    check("rst_ok", bus.frame_ok_o, 1'b0);
    check("rst_err", bus.frame_err_o, 1'b0);
    check("rst_err_code", bus.err_code_o, 2'b00);
    check("rst_err_cnt", bus.err_cnt_o, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table frames, launched back-to-back with the previous CHK response.
    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i]);
      check_after(vecs[i]);
    end

    // LEN above MAX_LEN aborts one cycle after the LEN strobe.
    send_byte(8'h55, 1);
    send_byte(8'hAA, 2);
    send_byte(8'h05, 0);
    push_err(2'b10);
    send_byte(8'h21, 0);
    check("len_err_pulse", bus.frame_err_o, 1'b1);
    check("len_err_busy", bus.busy_o, 1'b0);
    check("len_err_code", bus.err_code_o, 2'b10);
    check("len_err_len", bus.len_o, 8'h21);
    send_frame(vecs[2]);
    check_after(vecs[2]);

    // Silence after CMD: error visible exactly TIMEOUT_CYCLES+1 cycles after the strobe.
    send_byte(8'h55, 0);
    send_byte(8'hAA, 0);
    push_err(2'b11);
    send_byte(8'h10, 0);
    seen = -1;
    for (int k = 0; k <= 150; k++) begin
      if (bus.frame_err_o) begin
        seen = k + 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("timeout_latency", 32'(seen), 32'd101);
    check("timeout_code", bus.err_code_o, 2'b11);
    check("timeout_busy", bus.busy_o, 1'b0);
    check("timeout_cnt", bus.err_cnt_o, exp_cnt);

    // A byte arriving in the would-be expiry cycle keeps the frame alive.
    send_byte(8'h55, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h10, 99);
    send_byte(8'h00, 5);
    exp_q.push_back(ev(K_OK, 8'h00, 8'h00));
    send_byte(8'h10, 0);
    check("late_byte_ok", bus.frame_ok_o, 1'b1);
    check("late_byte_cnt", bus.err_cnt_o, exp_cnt);

    // Reset mid-payload discards the frame silently.
    send_byte(8'h55, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h10, 0);
    send_byte(8'h05, 0);
    exp_q.push_back(ev(K_PLD, 8'h01, 8'h00));
    send_byte(8'h01, 0);
    exp_q.push_back(ev(K_PLD, 8'h02, 8'h01));
    send_byte(8'h02, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy_o, 1'b0);
    check("midrst_cmd", bus.cmd_o, 8'h00);
    check("midrst_len", bus.len_o, 8'h00);
    check("midrst_cnt", bus.err_cnt_o, 8'h00);
    check("midrst_code", bus.err_code_o, 2'b00);
    check("midrst_pld", bus.pld_valid_o, 1'b0);
    exp_cnt  = 8'h00;
    exp_code = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(vecs[0]);
    check_after(vecs[0]);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      s = '{cmd:8'(i), len:8'd0, p0:8'h00, step:8'h00, chk:~8'(i), ok:1'b0, dup:1'b0};
      send_frame(s);
    end
    check("sat_cnt", bus.err_cnt_o, 8'hFF);
    check("sat_code", bus.err_code_o, 2'b01);

    repeat (5) begin
      @(posedge clk); #1;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
